// File: rtl/seq_pkg.sv
// State, opcode-class types and opcode map shared by the instruction sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT
   } opc_class_e;

   localparam logic [5:0] OPC_LOAD  = 6'd12;
   localparam logic [5:0] OPC_STORE = 6'd13;
   localparam logic [5:0] OPC_BR_LO = 6'd14;
   localparam logic [5:0] OPC_BR_HI = 6'd19;
   localparam logic [5:0] OPC_J_LO  = 6'd20;
   localparam logic [5:0] OPC_J_HI  = 6'd22;

   // The halt opcode is checked first so it wins even if configured inside another range.
   function automatic opc_class_e opc_class(input logic [5:0] opc, input logic [5:0] halt_opc);
      opc_class_e c;
      if (opc == halt_opc)
         c = CLS_HALT;
      else if (opc == OPC_LOAD)
         c = CLS_LOAD;
      else if (opc == OPC_STORE)
         c = CLS_STORE;
      else if (opc >= OPC_BR_LO && opc <= OPC_BR_HI)
         c = CLS_BRANCH;
      else if (opc >= OPC_J_LO && opc <= OPC_J_HI)
         c = CLS_JUMP;
      else
         c = CLS_ALU;
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited; expired flags the last allowed wait cycle.
// Latency: expired is a combinational compare on the registered count.
// Backpressure: none; clear dominates count.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (count)
         cnt <= cnt + 8'd1;
   end

   assign expired = (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer driving PC, IR, regfile and dmem strobes.
// Latency: branch 3, ALU/store/jump 4, load 5 cycles, plus one per memory wait cycle.
// Backpressure: memory req held until ack; MEM_TIMEOUT cycles without ack parks the block in ERR.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int HALT_OPC    = 63,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [31:0]      instruction,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             dmem_write,
   input  logic             dmem_ack,
   input  logic             branch_taken,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             reg_write,
   output logic             busy,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired_count,
   output logic [CNT_W-1:0] cycle_count
);

   state_e     state;
   logic [5:0] opc_q;
   opc_class_e opc_cls;
   logic       waiting;
   logic       tmr_expired;
   logic       retire;
   logic       unused_instr;

   assign opc_cls      = opc_class(opc_q, 6'(HALT_OPC));
   assign unused_instr = ^instruction[25:0];

   // Timer runs only while a request is outstanding and unacknowledged; any other cycle rearms it.
   assign waiting = (state == FETCH && !imem_ack) || (state == MEM && !dmem_ack);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!waiting),
      .count   (waiting),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opc_q <= '0;
      end else begin
         unique case (state)
            IDLE:   if (start) state <= FETCH;
            FETCH: begin
               if (imem_ack) begin
                  opc_q <= instruction[31:26];
                  state <= DECODE;
               end else if (tmr_expired) begin
                  state <= ERR;
               end
            end
            DECODE: state <= (opc_cls == CLS_HALT) ? HALT : EXEC;
            EXEC: begin
               if (opc_cls == CLS_LOAD || opc_cls == CLS_STORE)
                  state <= MEM;
               else if (opc_cls == CLS_BRANCH)
                  state <= FETCH;
               else
                  state <= WB;
            end
            MEM: begin
               if (dmem_ack)
                  state <= (opc_cls == CLS_STORE) ? FETCH : WB;
               else if (tmr_expired)
                  state <= ERR;
            end
            WB:     state <= FETCH;
            HALT:   state <= HALT;
            ERR:    state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req   = (state == FETCH);
   assign dmem_req   = (state == MEM);
   assign dmem_write = (state == MEM) && (opc_cls == CLS_STORE);
   assign busy       = !(state == IDLE || state == HALT || state == ERR);
   assign halted     = (state == HALT);
   assign error      = (state == ERR);

   // Strobes are masked during reset so a handshake completing in the reset cycle has no effect.
   assign ir_load   = !rst && (state == FETCH) && imem_ack;
   assign reg_write = !rst && (state == WB);
   assign pc_inc    = !rst && (((state == EXEC) && (opc_cls == CLS_BRANCH) && !branch_taken) ||
                               ((state == MEM) && (opc_cls == CLS_STORE) && dmem_ack) ||
                               ((state == WB) && (opc_cls != CLS_JUMP)));
   assign pc_load   = !rst && (((state == EXEC) && (opc_cls == CLS_BRANCH) && branch_taken) ||
                               ((state == WB) && (opc_cls == CLS_JUMP)));
   assign retire    = ((state == EXEC) && (opc_cls == CLS_BRANCH)) ||
                      ((state == MEM) && (opc_cls == CLS_STORE) && dmem_ack) ||
                      (state == WB);

   always_ff @(posedge clk) begin
      if (rst) begin
         retired_count <= '0;
         cycle_count   <= '0;
      end else begin
         if (retire && retired_count != '1)
            retired_count <= retired_count + CNT_W'(1);
         if (busy && cycle_count != '1)
            cycle_count <= cycle_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Script-driven bench: instruction-level rules expand into a per-cycle input/expected-output table.
module tb_instr_sequencer;

   localparam int CNT_W = 8;
   localparam int MAXC  = 255;
   localparam int HOPC  = 63;
   localparam int TMO   = 16;

   localparam int K_IDLE  = 0;
   localparam int K_FETCH = 1;
   localparam int K_HALT  = 2;
   localparam int K_ERR   = 3;

   typedef struct {
      bit        chk, rst, start, iack, dack, taken;
      bit [31:0] instr;
      bit        e_ireq, e_irl, e_dreq, e_dwr, e_pinc, e_pld, e_rw, e_busy, e_halt, e_err;
      int        e_ret, e_cyc;
      bit        pin;
      int        pin_ret, pin_cyc;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             imem_ack = 1'b0;
   logic [31:0]      instruction = '0;
   logic             dmem_ack = 1'b0;
   logic             branch_taken = 1'b0;
   logic             imem_req, ir_load, dmem_req, dmem_write, pc_inc, pc_load, reg_write;
   logic             busy, halted, error;
   logic [CNT_W-1:0] retired_count, cycle_count;

   ent_t script[$];
   int   ret_m = 0;
   int   cyc_m = 0;
   int   cur = 0;
   bit   cmp_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   instr_sequencer #(.HALT_OPC(HOPC), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .imem_req      (imem_req),
      .imem_ack      (imem_ack),
      .instruction   (instruction),
      .ir_load       (ir_load),
      .dmem_req      (dmem_req),
      .dmem_write    (dmem_write),
      .dmem_ack      (dmem_ack),
      .branch_taken  (branch_taken),
      .pc_inc        (pc_inc),
      .pc_load       (pc_load),
      .reg_write     (reg_write),
      .busy          (busy),
      .halted        (halted),
      .error         (error),
      .retired_count (retired_count),
      .cycle_count   (cycle_count)
   );

   // ---------------- reference model: instruction rules -> per-cycle table ----------------
   function automatic int cls_of(int opc);
      if (opc == HOPC)              return 5;
      if (opc == 12)                return 1;
      if (opc == 13)                return 2;
      if (opc >= 14 && opc <= 19)   return 3;
      if (opc >= 20 && opc <= 22)   return 4;
      return 0;
   endfunction

   // Don't-care inputs get random noise so ignored inputs really are exercised.
   function automatic ent_t blank(bit noisy);
      ent_t e;
      e = '{default: 0};
      e.chk = 1'b1;
      if (noisy) begin
         e.start = 1'($urandom_range(0, 1));
         e.iack  = 1'($urandom_range(0, 1));
         e.dack  = 1'($urandom_range(0, 1));
         e.taken = 1'($urandom_range(0, 1));
         e.instr = $urandom;
      end
      return e;
   endfunction

   function automatic ent_t bb();
      ent_t e;
      e = blank(1'b1);
      e.e_busy = 1'b1;
      return e;
   endfunction

   task automatic push(ent_t e, bit retire);
      e.e_ret = ret_m;
      e.e_cyc = cyc_m;
      script.push_back(e);
      if (e.rst) begin
         ret_m = 0;
         cyc_m = 0;
      end else begin
         if (retire && ret_m < MAXC) ret_m++;
         if (e.e_busy && cyc_m < MAXC) cyc_m++;
      end
   endtask

   task automatic gen_start();
      ent_t e;
      e = blank(1'b0);
      e.start = 1'b1;
      push(e, 1'b0);
   endtask

   task automatic gen_instr(int opc, int iw, int dw, bit taken);
      ent_t e;
      int   c;
      c = cls_of(opc);
      for (int k = 0; k < iw; k++) begin
         e = bb(); e.iack = 1'b0; e.e_ireq = 1'b1; push(e, 1'b0);
      end
      e = bb(); e.iack = 1'b1; e.instr = {6'(opc), 26'($urandom)};
      e.e_ireq = 1'b1; e.e_irl = 1'b1; push(e, 1'b0);
      e = bb(); push(e, 1'b0);                       // decode
      if (c == 5) return;
      e = bb(); e.taken = taken;                       // exec
      if (c == 3) begin
         e.e_pld = taken; e.e_pinc = !taken; push(e, 1'b1);
         return;
      end
      push(e, 1'b0);
      if (c == 1 || c == 2) begin
         for (int k = 0; k < dw; k++) begin
            e = bb(); e.dack = 1'b0; e.e_dreq = 1'b1; e.e_dwr = (c == 2); push(e, 1'b0);
         end
         e = bb(); e.dack = 1'b1; e.e_dreq = 1'b1; e.e_dwr = (c == 2);
         if (c == 2) begin
            e.e_pinc = 1'b1; push(e, 1'b1);
            return;
         end
         push(e, 1'b0);
      end
      e = bb(); e.e_rw = 1'b1;                         // writeback
      if (c == 4) e.e_pld = 1'b1; else e.e_pinc = 1'b1;
      push(e, 1'b1);
   endtask

   task automatic gen_fetch_timeout();
      ent_t e;
      for (int k = 0; k < TMO; k++) begin
         e = bb(); e.iack = 1'b0; e.e_ireq = 1'b1; push(e, 1'b0);
      end
   endtask

   task automatic gen_mem_timeout(int opc);
      ent_t e;
      e = bb(); e.iack = 1'b1; e.instr = {6'(opc), 26'($urandom)};
      e.e_ireq = 1'b1; e.e_irl = 1'b1; push(e, 1'b0);
      e = bb(); push(e, 1'b0);
      e = bb(); push(e, 1'b0);
      for (int k = 0; k < TMO; k++) begin
         e = bb(); e.dack = 1'b0; e.e_dreq = 1'b1; e.e_dwr = (opc == 13); push(e, 1'b0);
      end
   endtask

   task automatic gen_parked(bit is_err, int n);
      ent_t e;
      for (int k = 0; k < n; k++) begin
         e = blank(1'b1);
         e.start = 1'b1;
         if (is_err) e.e_err = 1'b1; else e.e_halt = 1'b1;
         push(e, 1'b0);
      end
   endtask

   // Reset with every request input asserted: must override start and any completing handshake.
   task automatic gen_reset(int kind, bit pin, int pr, int pc);
      ent_t e;
      e = blank(1'b1);
      e.rst = 1'b1; e.start = 1'b1; e.iack = 1'b1; e.dack = 1'b1;
      case (kind)
         K_FETCH: begin e.e_ireq = 1'b1; e.e_busy = 1'b1; end
         K_HALT:  e.e_halt = 1'b1;
         K_ERR:   e.e_err = 1'b1;
         default: ;
      endcase
      e.pin = pin; e.pin_ret = pr; e.pin_cyc = pc;
      push(e, 1'b0);
      push(blank(1'b0), 1'b0);
   endtask

   task automatic build();
      ent_t e;
      int   opc, iw, dw;
      e = blank(1'b0); e.rst = 1'b1; e.chk = 1'b0; push(e, 1'b0);
      push(blank(1'b0), 1'b0);
      push(blank(1'b0), 1'b0);
      // ALU, zero-wait
      gen_start(); gen_instr(0, 0, 0, 1'b0); gen_reset(K_FETCH, 1'b1, 1, 4);
      // LOAD, dmem ack after 3 wait cycles
      gen_start(); gen_instr(12, 0, 3, 1'b0); gen_reset(K_FETCH, 1'b1, 1, 8);
      // branch taken / not taken
      gen_start(); gen_instr(14, 0, 0, 1'b1); gen_reset(K_FETCH, 1'b1, 1, 3);
      gen_start(); gen_instr(14, 0, 0, 1'b0); gen_reset(K_FETCH, 1'b1, 1, 3);
      // STORE then JUMP
      gen_start(); gen_instr(13, 0, 0, 1'b0); gen_instr(20, 0, 0, 1'b0);
      gen_reset(K_FETCH, 1'b1, 2, 8);
      // fetch timeout
      gen_start(); gen_fetch_timeout(); gen_parked(1'b1, 3); gen_reset(K_ERR, 1'b1, 0, 16);
      // HALT
      gen_start(); gen_instr(HOPC, 0, 0, 1'b0); gen_parked(1'b0, 4); gen_reset(K_HALT, 1'b1, 0, 2);
      // longest tolerated wait, then a data-side timeout
      gen_start(); gen_instr(0, TMO - 1, 0, 1'b0); gen_mem_timeout(12);
      gen_parked(1'b1, 2); gen_reset(K_ERR, 1'b1, 1, 38);
      gen_start(); gen_instr(13, 0, TMO - 1, 1'b0); gen_mem_timeout(13);
      gen_parked(1'b1, 2); gen_reset(K_ERR, 1'b1, 1, 38);
      // long random run; both counters reach saturation
      gen_start();
      for (int n = 0; n < 300; n++) begin
         opc = $urandom_range(0, HOPC - 1);
         iw  = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3);
         dw  = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3);
         gen_instr(opc, iw, dw, 1'($urandom_range(0, 1)));
      end
      gen_instr(HOPC, $urandom_range(0, 2), 0, 1'b0);
      gen_parked(1'b0, 3);
      gen_reset(K_HALT, 1'b1, MAXC, MAXC);
   endtask

   // ---------------- compare ----------------
   task automatic cmp(string nm, int act, int exp, int idx);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic check_step(int i);
      ent_t e;
      e = script[i];
      if (!e.chk) return;
      cmp("imem_req",   int'(imem_req),   int'(e.e_ireq), i);
      cmp("ir_load",    int'(ir_load),    int'(e.e_irl),  i);
      cmp("dmem_req",   int'(dmem_req),   int'(e.e_dreq), i);
      cmp("dmem_write", int'(dmem_write), int'(e.e_dwr),  i);
      cmp("pc_inc",     int'(pc_inc),     int'(e.e_pinc), i);
      cmp("pc_load",    int'(pc_load),    int'(e.e_pld),  i);
      cmp("reg_write",  int'(reg_write),  int'(e.e_rw),   i);
      cmp("busy",       int'(busy),       int'(e.e_busy), i);
      cmp("halted",     int'(halted),     int'(e.e_halt), i);
      cmp("error",      int'(error),      int'(e.e_err),  i);
      cmp("retired_count", int'(retired_count), e.e_ret, i);
      cmp("cycle_count",   int'(cycle_count),   e.e_cyc, i);
      if (e.pin) begin
         cmp("pinned_retired", int'(retired_count), e.pin_ret, i);
         cmp("pinned_cycles",  int'(cycle_count),   e.pin_cyc, i);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) check_step(cur);
   end

   initial begin
      build();
      for (int i = 0; i < script.size(); i++) begin
         @(posedge clk);
         #1;
         rst          = script[i].rst;
         start        = script[i].start;
         imem_ack     = script[i].iack;
         instruction  = script[i].instr;
         dmem_ack     = script[i].dack;
         branch_taken = script[i].taken;
         cur          = i;
         cmp_en       = 1'b1;
      end
      @(posedge clk);
      #1 cmp_en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
